// File: rtl/fetch_queue_unit.sv
// Instruction prefetch unit: single-outstanding fetch engine feeding a DEPTH-entry {PC, NPC, instr} queue.
// Define FETCH_STALL_CNT_EN to add the stall_cnt output counting decode-starved cycles.
module fetch_queue_unit #(
  parameter int              BITS     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [BITS-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            j,
  input  logic [BITS-1:0] jPC,
  output logic            imem_req,
  output logic [BITS-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [BITS-1:0] imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [BITS-1:0] PC,
  output logic [BITS-1:0] NPC,
  output logic [BITS-1:0] instr
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [BITS-1:0] STEP = BITS'(PC_STEP);

  logic [BITS-1:0] fpc;
  logic [BITS-1:0] iss_addr;
  logic            out;
  logic            discard;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [BITS-1:0] pc_mem  [DEPTH];
  logic [BITS-1:0] ins_mem [DEPTH];
  logic            issue;
  logic            push;
  logic            pop;

  // Issue is allowed when the slot frees this cycle; count+out reserves room for the in-flight reply.
  always_comb begin
    imem_req  = !j && (!out || imem_rvalid) && ((32'(count) + 32'(out)) < 32'(DEPTH));
    issue     = imem_req && imem_ready;
    push      = imem_rvalid && out && !discard && !j;
    dec_valid = (count != '0) && !j;
    pop       = dec_valid && dec_ready;
  end

  assign imem_addr = fpc;

  always_comb begin
    PC    = '0;
    NPC   = '0;
    instr = '0;
    if (count != '0) begin
      PC    = pc_mem[rd_ptr];
      NPC   = pc_mem[rd_ptr] + STEP;
      instr = ins_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc      <= RESET_PC;
      iss_addr <= RESET_PC;
      out      <= 1'b0;
      discard  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (j) begin
      // A reply still in flight must be dropped when it finally shows up.
      fpc     <= jPC;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      out     <= out && !imem_rvalid;
      discard <= out && !imem_rvalid;
    end else begin
      if (issue) begin
        fpc      <= fpc + STEP;
        iss_addr <= fpc;
      end
      if (issue)
        out <= 1'b1;
      else if (imem_rvalid)
        out <= 1'b0;
      if (imem_rvalid && out)
        discard <= 1'b0;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= iss_addr;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (dec_ready && !dec_valid && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic against a decode-stream model.
module tb_fetch_queue_unit;
  localparam int          BITS     = 32;
  localparam int          DEPTH    = 4;
  localparam int          PC_STEP  = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst, j, imem_req, imem_ready, imem_rvalid, dec_valid, dec_ready;
  logic [31:0] jPC, imem_addr, imem_rdata, PC, NPC, instr;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int          stall_m = 0;
`endif

  always #5 clk = ~clk;

  fetch_queue_unit #(.BITS(BITS), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk(clk), .rst(rst), .j(j), .jPC(jPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .PC(PC), .NPC(NPC), .instr(instr)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        memq[$];
  int          checks = 0, errors = 0, cyc = 0, lat = 1, npops = 0;
  bit          lat_rand = 0, stray = 0;
  logic [31:0] efpc = RESET_PC, epc = RESET_PC;
  logic        s_req, s_dv, s_acc, s_pop, prev_rst;
  logic [31:0] s_addr, s_pc, s_npc, s_instr;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory reply, sample and check, cross the edge, advance the model.
  task automatic tick();
    logic rv, jj, rs;
    logic [31:0] jt;
    req_t r;
`ifdef FETCH_STALL_CNT_EN
    logic dr;
`endif
    if (stray) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    end else if (memq.size() > 0 && cyc >= memq[0].due) begin
      imem_rvalid = 1'b1; imem_rdata = ins_of(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_dv = dec_valid;
    s_pc = PC; s_npc = NPC; s_instr = instr;
    s_acc = imem_req && imem_ready;
    s_pop = dec_valid && dec_ready;
    rv = imem_rvalid && !stray; jj = j; jt = jPC; rs = rst;
`ifdef FETCH_STALL_CNT_EN
    dr = dec_ready;
`endif
    chk("imem_addr", imem_addr, efpc);
    if (j) begin
      chk("req_in_j", imem_req, 0);
      chk("dv_in_j", dec_valid, 0);
    end
    if (!rst && !prev_rst) chk("dv_in_rst", dec_valid, 0);
    if (!dec_valid && !j) begin
      chk("pc_empty", PC, 0);
      chk("npc_empty", NPC, 0);
      chk("instr_empty", instr, 0);
    end
    if (s_pop) begin
      chk("dec_pc", PC, epc);
      chk("dec_npc", NPC, epc + PC_STEP);
      chk("dec_instr", instr, ins_of(epc));
    end
    prev_rst = rst;
    @(posedge clk);
    cyc++;
    #1;
`ifdef FETCH_STALL_CNT_EN
    if (!rs) stall_m = 0;
    else if (dr && !s_dv) stall_m++;
`endif
    if (!rs) begin
      efpc = RESET_PC; epc = RESET_PC; memq.delete();
    end else begin
      if (rv && memq.size() > 0) void'(memq.pop_front());
      if (jj) begin
        efpc = jt; epc = jt;
      end else begin
        if (s_acc) begin
          r.addr = efpc;
          r.due  = cyc - 1 + (lat_rand ? int'($urandom_range(3, 1)) : lat);
          memq.push_back(r);
          efpc += PC_STEP;
        end
        if (s_pop) begin
          epc += PC_STEP;
          npops++;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 0; j = 0; jPC = 0; imem_ready = 1; dec_ready = 1;
    imem_rvalid = 0; imem_rdata = 0; prev_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    tick(); tick();

    // Reset release: two-cycle fill, then one instruction per cycle
    rst = 1;
    tick(); chk("fill_c0", s_dv, 0);
    tick(); chk("fill_c1", s_dv, 0);
    tick(); chk("first_dv", s_dv, 1); chk("first_pc", s_pc, 32'h100);
    tick(); chk("stream_dv1", s_dv, 1); chk("stream_pc1", s_pc, 32'h104);
    tick(); chk("stream_dv2", s_dv, 1); chk("stream_pc2", s_pc, 32'h108);
    chk("stream_npc2", s_npc, 32'h10C);

    // Decode back-pressure fills the queue, then drains in order
    dec_ready = 0;
    repeat (10) tick();
    chk("full_req", s_req, 0); chk("full_dv", s_dv, 1);
    dec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("drain_dv", s_dv, 1);
    end

    // Redirect with a slow reply in flight
    lat = 4;
    tick();
    for (int i = 0; i < 20 && !s_acc; i++) tick();
    chk("slow_acc", s_acc, 1);
    j = 1; jPC = 32'h200;
    tick();
    j = 0;
    tick(); chk("redir_addr", s_addr, 32'h200);
    for (int i = 0; i < 30 && !s_dv; i++) tick();
    chk("redir_dv", s_dv, 1); chk("redir_pc", s_pc, 32'h200);
    lat = 1;

    // Address wrap at the top of the space
    j = 1; jPC = 32'hFFFF_FFFC;
    tick();
    j = 0;
    tick();
    for (int i = 0; i < 20 && !s_acc; i++) tick();
    chk("wrap_iss", s_addr, 32'hFFFF_FFFC);
    tick(); chk("wrap_addr", s_addr, 32'h0);
    for (int i = 0; i < 20 && !s_dv; i++) tick();
    chk("wrap_pc", s_pc, 32'hFFFF_FFFC); chk("wrap_npc", s_npc, 32'h0);

    // Reset mid-operation with entries queued and a reply pending
    dec_ready = 0; j = 1; jPC = 32'h300;
    tick();
    j = 0;
    repeat (4) tick();
    chk("pre_rst_dv", s_dv, 1);
    rst = 0; imem_ready = 0;
    tick();
    rst = 1;
    tick(); chk("rst_dv", s_dv, 0); chk("rst_addr", s_addr, RESET_PC); chk("rst_pc", s_pc, 0);
    stray = 1;
    tick();
    stray = 0;
    tick(); chk("stray_dv", s_dv, 0);
    tick(); chk("stray_dv2", s_dv, 0);

`ifdef FETCH_STALL_CNT_EN
    dec_ready = 1; imem_ready = 0;
    repeat (5) tick();
    imem_ready = 1;
    repeat (4) tick();
    chk("stall_cnt", stall_cnt, stall_m);
`endif

    // Randomized traffic with redirects and variable latency
    imem_ready = 1; dec_ready = 1; lat_rand = 1;
    for (int i = 0; i < 400; i++) begin
      dec_ready  = ($urandom_range(3, 0) != 0);
      imem_ready = ($urandom_range(3, 0) != 0);
      j          = ($urandom_range(15, 0) == 0);
      jPC        = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    j = 0; lat_rand = 0; lat = 1; dec_ready = 1; imem_ready = 1;
    n0 = npops;
    repeat (20) tick();
    chk("drain_progress", (npops - n0 >= 10), 1);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt_end", stall_cnt, stall_m);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter BITS, default 32, PC/address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have parameter PC_STEP, default 4, sequential PC increment.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-007 SHALL have port j  in  1  redirect request (taken jump/branch).
REQ-008 SHALL have port jPC  in  BITS  redirect target.
REQ-009 SHALL have port imem_req  out  1  fetch request valid.
REQ-010 SHALL have port imem_addr  out  BITS  fetch address.
REQ-011 SHALL have port imem_ready  in  1  memory accepts request this cycle.
REQ-012 SHALL have port imem_rvalid  in  1  response valid; in order, >= 1 cycle after acceptance.
REQ-013 SHALL have port imem_rdata  in  BITS  response instruction.
REQ-014 SHALL have port dec_valid  out  1  head entry valid to decode.
REQ-015 SHALL have port dec_ready  in  1  decode accepts head entry.
REQ-016 SHALL have ports PC, NPC, instr  out  BITS each  head entry address, address+PC_STEP, instruction.

Function
REQ-017 SHALL hold fetch PC fpc, an outstanding flag out (max one outstanding request), a discard flag, and a DEPTH-entry FIFO of {PC, NPC, instr} with count 0..DEPTH.
REQ-018 SHALL assert imem_req combinationally iff j=0, (out=0 or imem_rvalid=1), and count+out < DEPTH; imem_addr SHALL equal fpc at all times.
REQ-019 On imem_req&imem_ready SHALL set out=1 and fpc <= fpc+PC_STEP modulo 2^BITS (wrap, no flag).
REQ-020 On imem_rvalid with out=1 and discard=0 SHALL push {issued addr, addr+PC_STEP, imem_rdata}; imem_rvalid with out=0 SHALL be ignored.
REQ-021 dec_valid SHALL equal (count != 0) and j=0; PC/NPC/instr SHALL show head entry; pop on dec_valid&dec_ready.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; REQ-018 SHALL guarantee no push into a full FIFO.
REQ-023 On j=1: fpc <= jPC, count <= 0, no push, no pop, no issue; if out=1 and imem_rvalid=0, discard <= 1, else discard <= 0.
REQ-024 Response arriving while discard=1 SHALL be dropped and clear discard and out; issue may occur in that cycle per REQ-018.
REQ-025 With imem_ready=1, 1-cycle response, dec_ready=1: first dec_valid SHALL occur 2 cycles after rst deasserts; sustained throughput SHALL be one instruction per cycle.
REQ-026 j in consecutive cycles SHALL take last target; j in same cycle as rst=0 SHALL be ignored.

Reset
REQ-027 While rst=0 at a clock edge: fpc <= RESET_PC, out <= 0, discard <= 0, count <= 0, FIFO pointers <= 0.
REQ-028 During and after reset, dec_valid=0 and imem_req follows REQ-018; PC/NPC/instr SHALL be 0 while count=0.
REQ-029 Reset mid-operation SHALL abandon any outstanding request; a later stray imem_rvalid SHALL be ignored per REQ-020.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN defined: output stall_cnt [31:0] SHALL count cycles with dec_ready=1 and dec_valid=0, saturating at 32'hFFFFFFFF, cleared by reset only.
REQ-031 Macro FETCH_STALL_CNT_EN undefined: stall_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset release, RESET_PC=0x100, 1-cycle memory, dec_ready=1 -> dec_valid at cycle 2, PC sequence 0x100,0x104,0x108 one per cycle, NPC=PC+4.
REQ-033 dec_ready=0 for 10 cycles, DEPTH=4 -> count reaches 4, imem_req=0 while count+out=4; release -> 4 entries drain in order, no loss/duplicate.
REQ-034 j=1, jPC=0x200 while request to 0x10C outstanding, response arrives 3 cycles later -> response dropped, next imem_addr=0x200, first dec PC=0x200.
REQ-035 fpc=0xFFFFFFFC, BITS=32 -> next imem_addr=0x00000000, NPC of head=0x00000000.
REQ-036 rst=0 asserted with FIFO holding 3 entries and out=1 -> next cycle dec_valid=0, imem_addr=RESET_PC, late imem_rvalid ignored.
REQ-037 With FETCH_STALL_CNT_EN, imem_ready=0 for 5 cycles, dec_ready=1 -> stall_cnt increases by 5 plus pipeline fill cycles; without macro -> build succeeds with no stall_cnt port.
